// File: rtl/pokey_kbd_pkg.sv
// Shared constants for the POKEY keyboard scanner: FSM encoding,
// default modifier scan positions and SKCTL bit positions.
package pokey_kbd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } kbd_state_t;

  localparam logic [5:0] KBD_CTRL_POS  = 6'h3C;
  localparam logic [5:0] KBD_SHIFT_POS = 6'h3D;

  localparam int SKCTL_DEBOUNCE_BIT = 0;
  localparam int SKCTL_SCAN_BIT     = 1;

  // SKCTL[1:0] == 00 holds the keyboard logic in its init state
  function automatic logic skctl_is_init(input logic [1:0] skctl);
    return (skctl == 2'b00);
  endfunction

  function automatic logic [7:0] kbcode_pack(input logic ctrl, input logic shift,
                                             input logic [5:0] code);
    return {ctrl, shift, code};
  endfunction

endpackage

// File: rtl/kbd_scan_counter.sv
// Prescaler and 6-bit scan address; raises sample on the last en pulse
// of each address dwell.
module kbd_scan_counter #(
  parameter int SCAN_DIV = 114
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       en,
  input  logic       init,
  input  logic       freeze,
  output logic [5:0] keyScan,
  output logic       sample
);

  localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

  logic [7:0] prescaler_r;
  logic [5:0] scan_r;
  logic       at_last_s;

  assign at_last_s = (prescaler_r == DIV_LAST);
  assign sample    = en & ~init & ~freeze & at_last_s;
  assign keyScan   = scan_r;

  // Advance the dwell prescaler and step the scan address on its wrap
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      prescaler_r <= 8'd0;
      scan_r      <= 6'd0;
    end else if (en) begin
      if (init) begin
        prescaler_r <= 8'd0;
        scan_r      <= 6'd0;
      end else if (!freeze) begin
        if (at_last_s) begin
          prescaler_r <= 8'd0;
          scan_r      <= scan_r + 6'd1;
        end else begin
          prescaler_r <= prescaler_r + 8'd1;
        end
      end else begin
        prescaler_r <= prescaler_r;
        scan_r      <= scan_r;
      end
    end else begin
      prescaler_r <= prescaler_r;
      scan_r      <= scan_r;
    end
  end

endmodule

// File: rtl/kbd_scan_ctrl.sv
// POKEY keyboard scan controller: walks the 64-key matrix, debounces a single
// key and reports KBCODE, SKSTAT key status and the keyboard IRQ request.
module kbd_scan_ctrl
  import pokey_kbd_pkg::*;
#(
  parameter int         SCAN_DIV  = 114,
  parameter logic [5:0] CTRL_POS  = KBD_CTRL_POS,
  parameter logic [5:0] SHIFT_POS = KBD_SHIFT_POS
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       en,
  input  logic [1:0] skctl,
  input  logic       kr1,
  input  logic       kr2,
  input  logic       kbIrqPend,
  output logic [5:0] keyScan,
  output logic [7:0] kbcode,
  output logic       keyDown,
  output logic       kShift,
  output logic       keyIrq,
  output logic       keyOvrun
);

  logic       init_s;
  logic       freeze_s;
  logic       debounce_s;
  logic       sample_s;
  logic       match_s;
  logic [5:0] scan_s;

  kbd_state_t state_r;
  logic [5:0] cmp_r;
  logic [7:0] kbcode_r;
  logic       key_down_r;
  logic       kshift_r;
  logic       ctrl_lat_r;
  logic       key_irq_r;
  logic       key_ovrun_r;

  assign init_s     = skctl_is_init(skctl);
  assign freeze_s   = ~skctl[SKCTL_SCAN_BIT];
  assign debounce_s = skctl[SKCTL_DEBOUNCE_BIT];
  assign match_s    = (scan_s == cmp_r);

  kbd_scan_counter #(
    .SCAN_DIV (SCAN_DIV)
  ) u_counter (
    .clk     (clk),
    .resetN  (resetN),
    .en      (en),
    .init    (init_s),
    .freeze  (freeze_s),
    .keyScan (scan_s),
    .sample  (sample_s)
  );

  // Key tracking FSM, modifier latches and registered status outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r     <= IDLE;
      cmp_r       <= 6'd0;
      kbcode_r    <= 8'h00;
      key_down_r  <= 1'b0;
      kshift_r    <= 1'b0;
      ctrl_lat_r  <= 1'b0;
      key_irq_r   <= 1'b0;
      key_ovrun_r <= 1'b0;
    end else begin
      key_irq_r   <= 1'b0;
      key_ovrun_r <= 1'b0;
      if (en && init_s) begin
        // kbcode deliberately survives the init state
        state_r    <= IDLE;
        cmp_r      <= 6'd0;
        key_down_r <= 1'b0;
        kshift_r   <= 1'b0;
        ctrl_lat_r <= 1'b0;
      end else if (sample_s) begin
        case (state_r)
          IDLE: begin
            if (!kr1) begin
              cmp_r <= scan_s;
              if (debounce_s) begin
                state_r <= CONFIRM;
              end else begin
                kbcode_r    <= kbcode_pack(ctrl_lat_r, kshift_r, scan_s);
                key_down_r  <= 1'b1;
                key_irq_r   <= 1'b1;
                key_ovrun_r <= kbIrqPend;
                state_r     <= HELD;
              end
            end
          end
          CONFIRM: begin
            if (match_s) begin
              if (!kr1) begin
                kbcode_r    <= kbcode_pack(ctrl_lat_r, kshift_r, cmp_r);
                key_down_r  <= 1'b1;
                key_irq_r   <= 1'b1;
                key_ovrun_r <= kbIrqPend;
                state_r     <= HELD;
              end else begin
                state_r <= IDLE;
              end
            end
          end
          HELD: begin
            if (match_s && kr1) begin
              if (debounce_s) begin
                state_r <= RELEASE;
              end else begin
                key_down_r <= 1'b0;
                state_r    <= IDLE;
              end
            end
          end
          RELEASE: begin
            if (match_s) begin
              if (kr1) begin
                key_down_r <= 1'b0;
                state_r    <= IDLE;
              end else begin
                state_r <= HELD;
              end
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
        // Non-blocking update: a key accepted on this en uses last pass's modifiers
        if (scan_s == CTRL_POS) begin
          ctrl_lat_r <= ~kr2;
        end
        if (scan_s == SHIFT_POS) begin
          kshift_r <= ~kr2;
        end
      end
    end
  end

  assign keyScan  = scan_s;
  assign kbcode   = kbcode_r;
  assign keyDown  = key_down_r;
  assign kShift   = kshift_r;
  assign keyIrq   = key_irq_r;
  assign keyOvrun = key_ovrun_r;

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Self-checking bench for kbd_scan_ctrl: a keyboard matrix plus a reference
// model built on en counts and a key-tracking phase variable.
module tb_kbd_scan_ctrl;

  localparam int DIV    = 4;
  localparam int PASS   = DIV * 64;
  localparam int CTRL_A = 8'h3C;
  localparam int SHFT_A = 8'h3D;

  logic       clk = 1'b0;
  logic       resetN;
  logic       en;
  logic [1:0] skctl;
  logic       kr1;
  logic       kr2;
  logic       kbIrqPend;
  logic [5:0] keyScan;
  logic [7:0] kbcode;
  logic       keyDown;
  logic       kShift;
  logic       keyIrq;
  logic       keyOvrun;

  kbd_scan_ctrl #(.SCAN_DIV(DIV)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .en        (en),
    .skctl     (skctl),
    .kr1       (kr1),
    .kr2       (kr2),
    .kbIrqPend (kbIrqPend),
    .keyScan   (keyScan),
    .kbcode    (kbcode),
    .keyDown   (keyDown),
    .kShift    (kShift),
    .keyIrq    (keyIrq),
    .keyOvrun  (keyOvrun)
  );

  always #10 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  // Matrix contents driven by the bench
  logic [63:0] keys_down = 64'd0;
  logic        ctrl_held = 1'b0;
  logic        shift_held = 1'b0;

  // Reference model: en count since init, key phase (0 idle, 1 seen once,
  // 2 held, 3 seen released once), tracked key and latched values
  int         n_en = 0;
  int         ph   = 0;
  int         last_samp = -1;
  logic [5:0] m_cmp = 6'd0;
  logic [7:0] m_kbc = 8'h00;
  logic       m_kd  = 1'b0;
  logic       m_ksh = 1'b0;
  logic       m_ctl = 1'b0;
  logic       m_irq = 1'b0;
  logic       m_ovr = 1'b0;
  int         irq_seen = 0;
  int         ovr_seen = 0;

  function automatic logic [5:0] scan_of(input int n);
    return 6'((n / DIV) % 64);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input logic clr_code);
    n_en = 0; ph = 0; m_cmp = 6'd0; m_kd = 1'b0; m_ksh = 1'b0; m_ctl = 1'b0;
    if (clr_code) m_kbc = 8'h00;
  endtask

  task automatic model_accept(input logic [5:0] code);
    m_kbc = {m_ctl, m_ksh, code};
    m_kd  = 1'b1;
    m_irq = 1'b1;
    m_ovr = kbIrqPend;
  endtask

  task automatic model_en(input logic k1, input logic k2);
    logic [5:0] sc;
    m_irq = 1'b0; m_ovr = 1'b0; last_samp = -1;
    if (skctl == 2'b00) begin
      model_reset(1'b0);
    end else if (skctl[1]) begin
      sc = scan_of(n_en);
      if ((n_en % DIV) == DIV - 1) begin
        last_samp = int'(sc);
        if (ph == 0) begin
          if (!k1) begin
            m_cmp = sc;
            if (skctl[0]) ph = 1;
            else begin model_accept(sc); ph = 2; end
          end
        end else if (sc == m_cmp) begin
          if (ph == 1) begin
            if (!k1) begin model_accept(m_cmp); ph = 2; end
            else ph = 0;
          end else if (ph == 2) begin
            if (k1) begin
              if (skctl[0]) ph = 3;
              else begin m_kd = 1'b0; ph = 0; end
            end
          end else begin
            if (k1) begin m_kd = 1'b0; ph = 0; end
            else ph = 2;
          end
        end
        if (int'(sc) == CTRL_A) m_ctl = ~k2;
        if (int'(sc) == SHFT_A) m_ksh = ~k2;
      end
      n_en = (n_en + 1) % PASS;
    end
  endtask

  // One en pulse: drive the matrix for the current address, then check
  task automatic step();
    logic [5:0] sc;
    logic k1, k2;
    sc = scan_of(n_en);
    k1 = ~keys_down[sc];
    k2 = ~(((int'(sc) == CTRL_A) && ctrl_held) || ((int'(sc) == SHFT_A) && shift_held));
    @(negedge clk);
    kr1 = k1; kr2 = k2; en = 1'b1;
    model_en(k1, k2);
    @(negedge clk);
    en = 1'b0;
    if (keyIrq === 1'b1) irq_seen++;
    if (keyOvrun === 1'b1) ovr_seen++;
    chk("keyScan", 32'(keyScan), 32'(scan_of(n_en)));
    chk("keyDown", 32'(keyDown), 32'(m_kd));
    chk("kbcode", 32'(kbcode), 32'(m_kbc));
    chk("kShift", 32'(kShift), 32'(m_ksh));
    chk("keyIrq", 32'(keyIrq), 32'(m_irq));
    chk("keyOvrun", 32'(keyOvrun), 32'(m_ovr));
    @(negedge clk);
    if (m_irq) begin
      chk("keyIrq_width", 32'(keyIrq), 32'd0);
      chk("keyOvrun_width", 32'(keyOvrun), 32'd0);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_sample(input int addr);
    int  cnt;
    logic found;
    cnt = 0; found = 1'b0;
    while (!found && cnt < PASS + 1) begin
      step();
      cnt++;
      if (last_samp == addr) found = 1'b1;
    end
    chk("wait_sample", 32'(found), 32'd1);
  endtask

  initial begin
    int k;
    int irq0;
    int frz;
    logic [7:0] held_code;

    resetN = 1'b0; en = 1'b0; skctl = 2'b00; kr1 = 1'b1; kr2 = 1'b1; kbIrqPend = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_keyScan", 32'(keyScan), 32'd0);
    chk("rst_kbcode", 32'(kbcode), 32'd0);
    chk("rst_keyDown", 32'(keyDown), 32'd0);
    chk("rst_irq", 32'(keyIrq), 32'd0);
    resetN = 1'b1;
    skctl  = 2'b11;

    // Scan stepping and wrap
    run(4);
    chk("scan_step1", 32'(keyScan), 32'd1);
    run(PASS - 4);
    chk("scan_wrap", 32'(keyScan), 32'd0);

    // Debounced press at 0x12 with SHIFT held
    shift_held = 1'b1;
    keys_down[6'h12] = 1'b1;
    irq0 = irq_seen;
    run(3 * PASS);
    chk("db_kbcode", 32'(kbcode), 32'h52);
    chk("db_keyDown", 32'(keyDown), 32'd1);
    chk("db_irq_count", 32'(irq_seen - irq0), 32'd1);
    chk("db_ovr_count", 32'(ovr_seen), 32'd0);
    keys_down = 64'd0;
    run(2 * PASS);
    chk("db_release", 32'(keyDown), 32'd0);

    // Bounce: 0x12 low on one pass only
    irq0 = irq_seen;
    keys_down[6'h12] = 1'b1;
    run_until_sample(8'h12);
    keys_down = 64'd0;
    run(2 * PASS);
    chk("bounce_irq", 32'(irq_seen - irq0), 32'd0);
    chk("bounce_kbcode", 32'(kbcode), 32'h52);

    // Overrun on a random key
    kbIrqPend = 1'b1;
    k = int'($urandom_range(0, 63));
    keys_down[k] = 1'b1;
    irq0 = irq_seen;
    run(3 * PASS);
    chk("ovr_count", 32'(ovr_seen), 32'd1);
    chk("ovr_irq_count", 32'(irq_seen - irq0), 32'd1);
    keys_down = 64'd0;
    kbIrqPend = 1'b0;
    run(2 * PASS);

    // No debounce: press and release each take effect on the first pass
    skctl = 2'b10;
    keys_down[6'h07] = 1'b1;
    run_until_sample(7);
    chk("nodb_press", 32'(keyDown), 32'd1);
    keys_down = 64'd0;
    run_until_sample(7);
    chk("nodb_release", 32'(keyDown), 32'd0);

    // Init mid-HELD, then freeze
    skctl = 2'b11;
    keys_down[6'h20] = 1'b1;
    run(2 * PASS);
    chk("init_pre_held", 32'(keyDown), 32'd1);
    held_code = m_kbc;
    skctl = 2'b00;
    run(3);
    chk("init_keyScan", 32'(keyScan), 32'd0);
    chk("init_keyDown", 32'(keyDown), 32'd0);
    chk("init_kbcode", 32'(kbcode), 32'(held_code));
    skctl = 2'b11;
    run(10);
    frz = int'(scan_of(n_en));
    skctl = 2'b01;
    run(20);
    chk("freeze_keyScan", 32'(keyScan), 32'(frz));
    skctl = 2'b11;
    keys_down = 64'd0;
    run(2 * PASS);

    // Reset asserted while a candidate waits for confirmation
    k = int'($urandom_range(0, 63));
    keys_down[k] = 1'b1;
    run_until_sample(k);
    chk("rst_pre_confirm", 32'(ph), 32'd1);
    irq0 = irq_seen;
    @(negedge clk);
    resetN = 1'b0;
    #1;
    chk("midrst_keyScan", 32'(keyScan), 32'd0);
    chk("midrst_kbcode", 32'(kbcode), 32'd0);
    chk("midrst_keyDown", 32'(keyDown), 32'd0);
    model_reset(1'b1);
    repeat (2) begin
      @(negedge clk);
      if (keyIrq === 1'b1) irq_seen++;
    end
    resetN = 1'b1;
    keys_down = 64'd0;
    run(DIV);
    chk("midrst_no_irq", 32'(irq_seen - irq0), 32'd0);
    run(PASS);

    // Randomised presses, modifiers, pending IRQ and debounce mode
    for (int r = 0; r < 6; r++) begin
      skctl      = $urandom_range(0, 1) ? 2'b11 : 2'b10;
      kbIrqPend  = 1'($urandom_range(0, 1));
      ctrl_held  = 1'($urandom_range(0, 1));
      shift_held = 1'($urandom_range(0, 1));
      keys_down  = 64'd0;
      keys_down[$urandom_range(0, 63)] = 1'b1;
      run(int'($urandom_range(1, 3)) * PASS + int'($urandom_range(0, 63)));
      keys_down = 64'd0;
      run(2 * PASS);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/kbd_scan_ctrl.md
Name: kbd_scan_ctrl

Overview:
- Keyboard scan controller for the POKEY core. Steps a 6-bit scan address through the 64-key matrix and samples the returned KR1/KR2 lines.
- Debounces key presses over two scan passes and produces KBCODE.
- Drives the keyDown, kShift and keyOvrun inputs of the SKSTAT register, plus the keyboard IRQ request to the IRQ logic.
- Runs on the 50 MHz system clock, gated by the 1.79 MHz negative-edge enable pulse.

Parameters:
- SCAN_DIV, 114: en pulses spent on each scan address (dwell). Legal range 2..255.
- CTRL_POS, 6'h3C: scan address at which kr2 low means CTRL is held.
- SHIFT_POS, 6'h3D: scan address at which kr2 low means SHIFT is held.

Ports:
- clk, input, 1: 50 MHz system clock.
- resetN, input, 1: asynchronous, active-low reset.
- en, input, 1: 1.79 MHz enable, one clk cycle wide (the enn pulse). All state advances only on en.
- skctl, input, 2: SKCTL[1:0]. Bit 0 enables debounce; bit 1 enables scan. Value 00 is the keyboard init state.
- kr1, input, 1: active-low key-pressed return for the current scan address.
- kr2, input, 1: active-low modifier return (CTRL/SHIFT) at CTRL_POS/SHIFT_POS.
- kbIrqPend, input, 1: keyboard IRQST bit still pending (not yet acknowledged).
- keyScan, output, 6: current scan address, driven to the matrix.
- kbcode, output, 8: {ctrl, shift, code[5:0]} of the last accepted key.
- keyDown, output, 1: key held (to SKSTAT bit 2, inverted there).
- kShift, output, 1: SHIFT held, as latched on the last scan pass.
- keyIrq, output, 1: one-clk pulse when a key is accepted.
- keyOvrun, output, 1: one-clk pulse when a key is accepted while kbIrqPend=1.

Behaviour:
- Reset (resetN=0, async): prescaler=0, keyScan=0, cmpReg=0, state=IDLE, kbcode=8'h00, keyDown=0, kShift=0, ctrlLat=0, keyIrq=0, keyOvrun=0.
- skctl=00 (init): same values as reset, applied synchronously on each en. kbcode is retained, not cleared.
- skctl=01: prescaler, keyScan and FSM are frozen; outputs hold.
- Prescaler:
  - Increments on each en and wraps at SCAN_DIV-1 -> 0.
  - The en pulse with prescaler==SCAN_DIV-1 is the sample point.
  - At the sample point, kr1/kr2 are evaluated for the current keyScan, then keyScan increments (63 -> 0 wrap).
- Modifiers:
  - At the sample point with keyScan==CTRL_POS: ctrlLat <= ~kr2.
  - At the sample point with keyScan==SHIFT_POS: kShift <= ~kr2.
- FSM, evaluated only at sample points:
  - IDLE:
    - kr1=0 -> cmpReg <= keyScan.
    - If skctl[0]=1, go to CONFIRM.
    - If skctl[0]=0, accept immediately and go to HELD.
  - CONFIRM, evaluated only when keyScan==cmpReg:
    - kr1=0 -> accept, go to HELD.
    - kr1=1 -> go to IDLE (bounce rejected).
  - HELD, evaluated only when keyScan==cmpReg:
    - kr1=1 and skctl[0]=1 -> go to RELEASE.
    - kr1=1 and skctl[0]=0 -> keyDown <= 0, go to IDLE.
    - kr1=0 -> stay.
  - RELEASE, evaluated only when keyScan==cmpReg:
    - kr1=1 -> keyDown <= 0, go to IDLE.
    - kr1=0 -> go back to HELD.
  - Other scan addresses are ignored in CONFIRM, HELD and RELEASE. Only one key is tracked.
- Accept action:
  - kbcode <= {ctrlLat, kShift, cmpReg}, keyDown <= 1, keyIrq=1 for one clk.
  - keyOvrun=1 for one clk if kbIrqPend=1 at that same en.
  - In IDLE with debounce off, use keyScan in place of cmpReg.
- Latency: every registered output changes in the clk cycle after the sampling en. keyIrq and keyOvrun are high for exactly one clk.
- Simultaneous events:
  - A modifier sample and a key sample on the same en: the modifier latch updates after kbcode is captured, so the previous pass value is used.
  - skctl change takes effect at the next en.
- Reset asserted mid-operation: all state is cleared immediately. No pulse is emitted during reset or on the release of reset.

Decomposition:
- Shared constant set pokey_kbd_pkg holds:
  - FSM state encoding: IDLE=2'd0, CONFIRM=2'd1, HELD=2'd2, RELEASE=2'd3.
  - Default CTRL_POS/SHIFT_POS.
  - SKCTL bit indices.
- One sub-module, kbd_scan_counter, contains the prescaler plus the 6-bit scan address. Its outputs are keyScan and a sample strobe. It has init, freeze and wrap logic.
- The FSM, modifier latches and output logic live in kbd_scan_ctrl.

Test Plan (all runs use SCAN_DIV=4, skctl=11 unless stated):
- Reset release: after resetN rises, keyScan steps 0, 1, 2 every 4 en pulses and wraps 63 -> 0 after 256 en. keyDown=0, kbcode=00.
- Debounced press: hold kr1=0 whenever keyScan==6'h12, with kShift latched 1. After the second pass, keyDown=1 and kbcode=8'h52. keyIrq pulses once for 1 clk. keyOvrun stays 0 (kbIrqPend=0).
- Bounce reject: kr1=0 at 6'h12 on one pass only. State returns to IDLE, keyIrq never fires, kbcode unchanged.
- Overrun: repeat the debounced press with kbIrqPend=1. keyIrq and keyOvrun pulse on the same clk.
- Release and no-debounce: with skctl=10, kr1=0 at 6'h07 gives keyDown=1 on the first pass. The first pass with kr1=1 at 6'h07 gives keyDown=0.
- Init/freeze: skctl=00 mid-HELD gives keyScan=0, keyDown=0, kbcode held. skctl=01 freezes keyScan across 20 en. resetN=0 mid-CONFIRM clears everything with no keyIrq.
